game_credit_timer_mc: RTL and testbench

- Multi-channel successor to the single-station arcade credit timer.
- Each of N_CH stations holds a credit balance. Credit is added through a valid/ready load port and is spent at 1 or BOOST_RATE units per tick while the station runs.
- Each channel drives yellow (low-credit) and red (expired) lamps plus a one-cycle expiry pulse to the cabinet controller.
- A shared prescaler sets the billing tick rate.

---
 rtl/game_credit_timer_mc_if.sv | 29 ++
 rtl/game_credit_timer_mc.sv | 70 +++++++
 tb/tb_game_credit_timer_mc.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/game_credit_timer_mc_if.sv
// game_credit_timer_mc_if: load port, spend controls and lamp outputs of the credit timer (ovf present with GAME_OVF_FLAG_EN)
interface game_credit_timer_mc_if #(
    parameter int N_CH = 4,
    parameter int W    = 12
);
    localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
    logic              ld_valid;
    logic              ld_ready;
    logic [CW-1:0]     ld_ch;
    logic [W-1:0]      ld_amount;
    logic [N_CH-1:0]   run;
    logic [N_CH-1:0]   boost;
    logic [N_CH*W-1:0] remain;
    logic [N_CH-1:0]   yellow;
    logic [N_CH-1:0]   red;
    logic [N_CH-1:0]   expire_pulse;
`ifdef GAME_OVF_FLAG_EN
    logic [N_CH-1:0]   ovf;
    modport master (output ld_valid, ld_ch, ld_amount, run, boost,
                    input ld_ready, remain, yellow, red, expire_pulse, ovf);
    modport slave  (input ld_valid, ld_ch, ld_amount, run, boost,
                    output ld_ready, remain, yellow, red, expire_pulse, ovf);
`else
    modport master (output ld_valid, ld_ch, ld_amount, run, boost,
                    input ld_ready, remain, yellow, red, expire_pulse);
    modport slave  (input ld_valid, ld_ch, ld_amount, run, boost,
                    output ld_ready, remain, yellow, red, expire_pulse);
`endif
endinterface

// File: rtl/game_credit_timer_mc.sv
// game_credit_timer_mc: per-station credit balances with saturating loads, tick-paced spend and lamp FSM; GAME_OVF_FLAG_EN adds sticky ovf flags
module game_credit_timer_mc #(
    parameter int N_CH       = 4,
    parameter int W          = 12,
    parameter int LOW_THRESH = 10,
    parameter int BOOST_RATE = 2,
    parameter int TICK_DIV   = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    game_credit_timer_mc_if.slave bus
);
    localparam int CW = N_CH > 1 ? $clog2(N_CH) : 1;
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, ACTIVE, LOW, EXPIRED} state_t;
    function automatic state_t classify(input logic [W-1:0] v);
        return v > W'(LOW_THRESH) ? ACTIVE : (v == '0 ? IDLE : LOW);
    endfunction
    logic [PW-1:0] cnt;
    logic          tick;
    logic          ready_q;
    assign tick         = cnt == PW'(TICK_DIV - 1);
    assign bus.ld_ready = ready_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            cnt     <= '0;
            ready_q <= 1'b0;
        end else begin
            cnt     <= tick ? '0 : cnt + 1'b1;
            ready_q <= 1'b1;
        end
    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        logic [W-1:0] bal, bal_nx, dec;
        logic [W:0]   sum;
        logic         load, sat, spend, pulse;
        state_t       state, state_nx;
        assign load  = bus.ld_valid && ready_q && bus.ld_ch == CW'(i) && bus.ld_amount != '0;
        assign sum   = {1'b0, bal} + {1'b0, bus.ld_amount};
        assign sat   = sum[W];
        assign dec   = bus.boost[i] ? W'(BOOST_RATE) : W'(1);
        // a load owns the channel for this tick; an empty balance has nothing to spend
        assign spend = tick && bus.run[i] && !load && bal != '0;
        always_comb begin
            bal_nx   = load ? (sat ? '1 : sum[W-1:0]) : spend ? (bal < dec ? '0 : bal - dec) : bal;
            state_nx = load  ? (state == EXPIRED && sat ? EXPIRED : classify(bal_nx)) :
                       spend ? (state == EXPIRED || bal_nx == '0 ? EXPIRED : classify(bal_nx)) : state;
        end
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) begin
                bal   <= '0;
                state <= IDLE;
                pulse <= 1'b0;
            end else begin
                bal   <= bal_nx;
                state <= state_nx;
                pulse <= state_nx == EXPIRED && state != EXPIRED;
            end
        assign bus.remain[i*W +: W] = bal;
        assign bus.yellow[i]        = state == LOW;
        assign bus.red[i]           = state == EXPIRED;
        assign bus.expire_pulse[i]  = pulse;
`ifdef GAME_OVF_FLAG_EN
        logic ovf;
        always_ff @(posedge clk or negedge rst_n)
            if (!rst_n) ovf <= 1'b0;
            else if (load) ovf <= sat;
        assign bus.ovf[i] = ovf;
`endif
    end
endmodule

// File: tb/tb_game_credit_timer_mc.sv
// tb_game_credit_timer_mc: directed checks of load, spend, lamps, prescaler and reset on two timer instances
module tb_game_credit_timer_mc;
    localparam int N = 4;
    localparam int W = 12;
    logic clk;
    logic rst_n;
    int   cmp;
    int   mis;
    game_credit_timer_mc_if #(.N_CH(N), .W(W)) b0();
    game_credit_timer_mc_if #(.N_CH(N), .W(W)) b1();
    game_credit_timer_mc #(.N_CH(N), .W(W), .TICK_DIV(1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    game_credit_timer_mc #(.N_CH(N), .W(W), .TICK_DIV(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [W-1:0] r0(input int c);
        return b0.remain[c*W +: W];
    endfunction

    function automatic logic [W-1:0] r1(input int c);
        return b1.remain[c*W +: W];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load0(input int c, input int amt);
        b0.ld_valid  = 1'b1;
        b0.ld_ch     = 2'(c);
        b0.ld_amount = 12'(amt);
        step();
        b0.ld_valid  = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        cmp++; if (b0.remain !== '0) begin mis++; $display("FAIL reset_remain: got %0h expected 0", b0.remain); end
        cmp++; if ({b0.yellow, b0.red, b0.expire_pulse} !== '0) begin mis++; $display("FAIL reset_lamps: got %0h expected 0", {b0.yellow, b0.red, b0.expire_pulse}); end
        cmp++; if (b0.ld_ready !== 1'b0) begin mis++; $display("FAIL reset_ready_low: got %0d expected 0", b0.ld_ready); end
        cmp++; if (b1.remain !== '0) begin mis++; $display("FAIL reset_remain1: got %0h expected 0", b1.remain); end
        @(negedge clk);
        rst_n = 1'b1;
        step();
        cmp++; if (b0.ld_ready !== 1'b1) begin mis++; $display("FAIL reset_ready_high: got %0d expected 1", b0.ld_ready); end
        cmp++; if (b1.ld_ready !== 1'b1) begin mis++; $display("FAIL reset_ready_high1: got %0d expected 1", b1.ld_ready); end
    endtask

    task automatic test_prescaler();
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        step();
        b1.ld_valid = 1'b1; b1.ld_ch = 2'd0; b1.ld_amount = 12'd20; b1.run = 4'b0001;
        step();
        b1.ld_valid = 1'b0;
        cmp++; if (r1(0) !== 12'd20) begin mis++; $display("FAIL prescale_load: got %0d expected 20", r1(0)); end
        for (int e = 3; e <= 14; e++) begin
            step();
            cmp++; if (r1(0) !== 12'(20 - e / 4)) begin mis++; $display("FAIL prescale_edge%0d: got %0d expected %0d", e, r1(0), 20 - e / 4); end
        end
        b1.run = 4'b0000;
        for (int k = 0; k < 6; k++) begin
            step();
            cmp++; if (r1(0) !== 12'd17) begin mis++; $display("FAIL prescale_freeze: got %0d expected 17", r1(0)); end
            cmp++; if ({b1.yellow[0], b1.red[0]} !== 2'b00) begin mis++; $display("FAIL prescale_lamps: got %0b expected 00", {b1.yellow[0], b1.red[0]}); end
        end
    endtask

    task automatic test_countdown();
        b0.run = 4'b0001;
        load0(0, 15);
        cmp++; if (r0(0) !== 12'd15) begin mis++; $display("FAIL count_load: got %0d expected 15", r0(0)); end
        cmp++; if ({b0.yellow[0], b0.red[0]} !== 2'b00) begin mis++; $display("FAIL count_lamps0: got %0b expected 00", {b0.yellow[0], b0.red[0]}); end
        for (int k = 1; k <= 15; k++) begin
            int r;
            r = 15 - k;
            step();
            cmp++; if (r0(0) !== 12'(r)) begin mis++; $display("FAIL count_remain: got %0d expected %0d", r0(0), r); end
            cmp++; if (b0.yellow[0] !== (r > 0 && r <= 10)) begin mis++; $display("FAIL count_yellow at %0d: got %0d", r, b0.yellow[0]); end
            cmp++; if (b0.red[0] !== (r == 0)) begin mis++; $display("FAIL count_red at %0d: got %0d", r, b0.red[0]); end
            cmp++; if (b0.expire_pulse[0] !== (r == 0)) begin mis++; $display("FAIL count_pulse at %0d: got %0d", r, b0.expire_pulse[0]); end
        end
        step();
        cmp++; if (r0(0) !== 12'd0) begin mis++; $display("FAIL count_hold: got %0d expected 0", r0(0)); end
        cmp++; if (b0.red[0] !== 1'b1) begin mis++; $display("FAIL count_red_hold: got %0d expected 1", b0.red[0]); end
        cmp++; if (b0.expire_pulse[0] !== 1'b0) begin mis++; $display("FAIL count_pulse_once: got %0d expected 0", b0.expire_pulse[0]); end
        b0.run = 4'b0000;
    endtask

    task automatic test_boost_clamp();
        load0(1, 1);
        cmp++; if (r0(1) !== 12'd1) begin mis++; $display("FAIL boost_load: got %0d expected 1", r0(1)); end
        cmp++; if (b0.yellow[1] !== 1'b1) begin mis++; $display("FAIL boost_yellow: got %0d expected 1", b0.yellow[1]); end
        b0.run = 4'b0010; b0.boost = 4'b0010;
        step();
        cmp++; if (r0(1) !== 12'd0) begin mis++; $display("FAIL boost_clamp: got %0d expected 0", r0(1)); end
        cmp++; if (b0.red[1] !== 1'b1) begin mis++; $display("FAIL boost_red: got %0d expected 1", b0.red[1]); end
        cmp++; if (b0.expire_pulse[1] !== 1'b1) begin mis++; $display("FAIL boost_pulse: got %0d expected 1", b0.expire_pulse[1]); end
        b0.run = 4'b0000; b0.boost = 4'b0000;
        step();
        cmp++; if (r0(1) !== 12'd0) begin mis++; $display("FAIL boost_hold: got %0d expected 0", r0(1)); end
        cmp++; if (b0.expire_pulse[1] !== 1'b0) begin mis++; $display("FAIL boost_pulse_end: got %0d expected 0", b0.expire_pulse[1]); end
    endtask

    task automatic test_saturate();
        load0(2, 4000);
        cmp++; if (r0(2) !== 12'd4000) begin mis++; $display("FAIL sat_first: got %0d expected 4000", r0(2)); end
        load0(2, 200);
        cmp++; if (r0(2) !== 12'd4095) begin mis++; $display("FAIL sat_clip: got %0d expected 4095", r0(2)); end
`ifdef GAME_OVF_FLAG_EN
        cmp++; if (b0.ovf[2] !== 1'b1) begin mis++; $display("FAIL sat_ovf_set: got %0d expected 1", b0.ovf[2]); end
`endif
        load0(2, 0);
        cmp++; if (r0(2) !== 12'd4095) begin mis++; $display("FAIL sat_zero_load: got %0d expected 4095", r0(2)); end
`ifdef GAME_OVF_FLAG_EN
        cmp++; if (b0.ovf[2] !== 1'b1) begin mis++; $display("FAIL sat_ovf_sticky: got %0d expected 1", b0.ovf[2]); end
`endif
        b0.run = 4'b0100;
        step();
        b0.run = 4'b0000;
        cmp++; if (r0(2) !== 12'd4094) begin mis++; $display("FAIL sat_drop: got %0d expected 4094", r0(2)); end
        load0(2, 1);
        cmp++; if (r0(2) !== 12'd4095) begin mis++; $display("FAIL sat_exact: got %0d expected 4095", r0(2)); end
`ifdef GAME_OVF_FLAG_EN
        cmp++; if (b0.ovf[2] !== 1'b0) begin mis++; $display("FAIL sat_ovf_clear: got %0d expected 0", b0.ovf[2]); end
`endif
    endtask

    task automatic test_priority();
        load0(3, 30);
        cmp++; if (r0(3) !== 12'd30) begin mis++; $display("FAIL prio_ch3_load: got %0d expected 30", r0(3)); end
        b0.run = 4'b1010;
        load0(1, 5);
        cmp++; if (r0(1) !== 12'd5) begin mis++; $display("FAIL prio_ch1_skip: got %0d expected 5", r0(1)); end
        cmp++; if (r0(3) !== 12'd29) begin mis++; $display("FAIL prio_ch3_spend: got %0d expected 29", r0(3)); end
        cmp++; if ({b0.yellow[1], b0.red[1]} !== 2'b10) begin mis++; $display("FAIL prio_ch1_lamps: got %0b expected 10", {b0.yellow[1], b0.red[1]}); end
        step();
        cmp++; if (r0(1) !== 12'd4) begin mis++; $display("FAIL prio_ch1_next: got %0d expected 4", r0(1)); end
        cmp++; if (r0(3) !== 12'd28) begin mis++; $display("FAIL prio_ch3_next: got %0d expected 28", r0(3)); end
        b0.run = 4'b0000;
    endtask

    task automatic test_freeze_reset();
        load0(0, 9);
        cmp++; if (r0(0) !== 12'd9) begin mis++; $display("FAIL frz_load: got %0d expected 9", r0(0)); end
        cmp++; if ({b0.yellow[0], b0.red[0]} !== 2'b10) begin mis++; $display("FAIL frz_reload_lamps: got %0b expected 10", {b0.yellow[0], b0.red[0]}); end
        b0.run = 4'b0001;
        step();
        step();
        b0.run = 4'b0000;
        cmp++; if (r0(0) !== 12'd7) begin mis++; $display("FAIL frz_spend: got %0d expected 7", r0(0)); end
        for (int k = 0; k < 4; k++) begin
            step();
            cmp++; if (r0(0) !== 12'd7) begin mis++; $display("FAIL frz_hold: got %0d expected 7", r0(0)); end
            cmp++; if ({b0.yellow[0], b0.red[0]} !== 2'b10) begin mis++; $display("FAIL frz_lamps: got %0b expected 10", {b0.yellow[0], b0.red[0]}); end
        end
        b0.run = 4'b0001;
        step();
        cmp++; if (r0(0) !== 12'd6) begin mis++; $display("FAIL frz_resume: got %0d expected 6", r0(0)); end
        #2;
        rst_n = 1'b0;
        #1;
        cmp++; if (b0.remain !== '0) begin mis++; $display("FAIL arst_remain: got %0h expected 0", b0.remain); end
        cmp++; if ({b0.yellow, b0.red, b0.expire_pulse} !== '0) begin mis++; $display("FAIL arst_lamps: got %0h expected 0", {b0.yellow, b0.red, b0.expire_pulse}); end
        cmp++; if (b0.ld_ready !== 1'b0) begin mis++; $display("FAIL arst_ready: got %0d expected 0", b0.ld_ready); end
        cmp++; if (b1.remain !== '0) begin mis++; $display("FAIL arst_remain1: got %0h expected 0", b1.remain); end
        #2;
        rst_n = 1'b1;
        #1;
        cmp++; if (b0.ld_ready !== 1'b0) begin mis++; $display("FAIL arst_ready_wait: got %0d expected 0", b0.ld_ready); end
        step();
        cmp++; if (b0.ld_ready !== 1'b1) begin mis++; $display("FAIL arst_ready_back: got %0d expected 1", b0.ld_ready); end
        cmp++; if ({r0(0), b0.red[0], b0.expire_pulse[0]} !== 14'd0) begin mis++; $display("FAIL arst_idle_spend: got %0h expected 0", {r0(0), b0.red[0], b0.expire_pulse[0]}); end
        b0.run = 4'b0000;
    endtask

    initial begin
        cmp = 0;
        mis = 0;
        rst_n = 1'b0;
        b0.ld_valid = 1'b0; b0.ld_ch = '0; b0.ld_amount = '0; b0.run = '0; b0.boost = '0;
        b1.ld_valid = 1'b0; b1.ld_ch = '0; b1.ld_amount = '0; b1.run = '0; b1.boost = '0;
        test_reset();
        test_prescaler();
        test_countdown();
        test_boost_clamp();
        test_saturate();
        test_priority();
        test_freeze_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
        $finish;
    end
endmodule
